// File: rtl/serial_deframer_pkg.sv
// Shared types and line-level constants for the serial deframer.
// The FSM state enum is shared so that any observer decodes the same encoding.
package serial_deframer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage : serial_deframer_pkg

// File: rtl/serial_deframer_if.sv
// Output word handshake between the deframer and its consumer.
// The deframer is the master; it drives the word, parity flag and valid.
interface serial_deframer_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] out_data;
    logic             out_perr;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_perr,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_perr,
        input  out_valid,
        output out_ready
    );

endinterface : serial_deframer_if

// File: rtl/serial_deframer_out_reg.sv
// One-entry valid/ready holding register for completed words.
// A word that arrives while the held word is stalled is dropped and flags overrun.
module deframer_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_perr,
    input  logic             ovr_clr,
    output logic             overrun,
    serial_deframer_if.master out_if
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;
    logic             accept;
    logic             drop;

    always_comb begin
        accept  = load && (!valid_q || out_if.out_ready);
        drop    = load && valid_q && !out_if.out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;

        // A consumer pop in the same cycle frees the slot for the incoming word.
        if (accept) begin
            valid_d = 1'b1;
            data_d  = load_data;
            perr_d  = load_perr;
        end else if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
        end

        if (drop) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_perr  = perr_q;
    assign overrun          = ovr_q;

endmodule : deframer_out_reg

// File: rtl/serial_deframer.sv
// Serial frame receiver: start bit, WIDTH data bits MSB first, optional even
// parity, stop bit. Completed words go to a one-entry valid/ready register.
module serial_deframer
    import serial_deframer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic serial_in,
    serial_deframer_if.master out_if,
    output logic frame_err,
    output logic overrun,
    input  logic ovr_clr
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic             perr_q, perr_d;
    logic             frame_err_q, frame_err_d;
    logic             deliver;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        perr_d      = perr_q;
        frame_err_d = 1'b0;
        deliver     = 1'b0;

        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (serial_in == START_BIT) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        perr_d  = 1'b0;
                    end
                end
                ST_DATA: begin
                    rx_d  = {rx_q[WIDTH-2:0], serial_in};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    perr_d  = ^{rx_q, serial_in};
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    // A bad stop bit discards the word; the output register is not touched.
                    state_d = ST_IDLE;
                    if (serial_in == STOP_BIT) begin
                        deliver = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            perr_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            perr_q      <= perr_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

    deframer_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (deliver),
        .load_data(rx_q),
        .load_perr(perr_q),
        .ovr_clr  (ovr_clr),
        .overrun  (overrun),
        .out_if   (out_if)
    );

endmodule : serial_deframer

// File: tb/tb_serial_deframer.sv
// Bench for serial_deframer: directed frame table, hand-written corner sequences
// and random line traffic, all checked against a frame-level reference model.
module tb_serial_deframer;
    import serial_deframer_pkg::*;

    localparam int W         = 4;
    localparam bit PE        = 1'b1;
    localparam int FRAME_LEN = W + (PE ? 1 : 0) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic serial_in = IDLE_LEVEL;
    logic ovr_clr = 1'b0;
    logic frame_err;
    logic overrun;

    serial_deframer_if #(.WIDTH(W)) bus ();

    serial_deframer #(
        .WIDTH(W),
        .PARITY_EN(PE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .serial_in(serial_in),
        .out_if   (bus),
        .frame_err(frame_err),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: bits after a start bit are collected into a list and the
    // frame is judged once the list has its full length.
    logic         m_busy;
    logic         m_bits[$];
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_perr;
    logic         m_ovr;
    logic         m_ferr;

    typedef struct {
        logic [W-1:0] data;
        logic         par;
        logic         stop;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic         exp_perr;
        logic         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_bits.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_perr  = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic b, input logic rdy, input logic clr);
        logic         deliver = 1'b0;
        logic         fe = 1'b0;
        logic         drop;
        logic [W-1:0] wd = '0;
        logic         wp = 1'b0;
        int           ones = 0;
        if (e) begin
            if (!m_busy) begin
                if (b == START_BIT) begin
                    m_busy = 1'b1;
                    m_bits.delete();
                end
            end else begin
                m_bits.push_back(b);
                if (m_bits.size() == FRAME_LEN) begin
                    for (int i = 0; i < W; i++) begin
                        wd = {wd[W-2:0], m_bits[i]};
                        ones += int'(m_bits[i]);
                    end
                    if (PE) wp = ((ones + int'(m_bits[W])) % 2) != 0;
                    m_busy = 1'b0;
                    if (m_bits[FRAME_LEN-1] == STOP_BIT) deliver = 1'b1;
                    else fe = 1'b1;
                end
            end
        end
        drop = deliver && m_valid && !rdy;
        if (deliver && !drop) begin
            m_valid = 1'b1;
            m_data  = wd;
            m_perr  = wp;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        m_ferr = fe;
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("out_perr", 32'(bus.out_perr), 32'(m_perr));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic tick(input logic e, input logic b, input logic rdy, input logic clr);
        en            = e;
        serial_in     = b;
        bus.out_ready = rdy;
        ovr_clr       = clr;
        model_edge(e, b, rdy, clr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send_bit(input logic b, input logic rdy, input int period);
        for (int k = 1; k < period; k++) tick(1'b0, 1'($urandom_range(0, 1)), rdy, 1'b0);
        tick(1'b1, b, rdy, 1'b0);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stop,
                              input logic rdy, input int period);
        send_bit(START_BIT, rdy, period);
        for (int i = W - 1; i >= 0; i--) send_bit(d[i], rdy, period);
        if (PE) send_bit(par, rdy, period);
        send_bit(stop, rdy, period);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        model_reset();

        vecs[0] = '{4'h3, 1'b0, STOP_BIT, 1'b1, 4'h3, 1'b0, 1'b0};
        vecs[1] = '{4'hA, 1'b0, STOP_BIT, 1'b1, 4'hA, 1'b0, 1'b0};
        vecs[2] = '{4'h6, 1'b1, STOP_BIT, 1'b1, 4'h6, 1'b1, 1'b0};
        vecs[3] = '{4'hF, 1'b0, 1'b1,     1'b0, 4'h6, 1'b1, 1'b1};
        vecs[4] = '{4'h1, 1'b1, STOP_BIT, 1'b1, 4'h1, 1'b0, 1'b0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_perr", 32'(bus.out_perr), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;

        // Reset in the middle of DATA discards the partial word
        tick(1'b1, START_BIT, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            tick(1'b1, IDLE_LEVEL, 1'b1, 1'b0);
            chk("after_rst_valid", 32'(bus.out_valid), 32'd0);
        end

        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 1'b1, 1);
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_perr", i), 32'(bus.out_perr), 32'(vecs[i].exp_perr));
            chk($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
            tick(1'b1, IDLE_LEVEL, 1'b1, 1'b0);
            chk($sformatf("vec%0d_valid_next", i), 32'(bus.out_valid), 32'd0);
            chk($sformatf("vec%0d_ferr_next", i), 32'(frame_err), 32'd0);
        end

        // Stalled consumer: the second word is dropped and overrun latches
        send_frame(4'h5, 1'b0, STOP_BIT, 1'b0, 1);
        chk("stall_first_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_first_data", 32'(bus.out_data), 32'h5);
        send_frame(4'h9, 1'b0, STOP_BIT, 1'b0, 1);
        chk("stall_held_data", 32'(bus.out_data), 32'h5);
        chk("stall_overrun", 32'(overrun), 32'd1);
        tick(1'b1, IDLE_LEVEL, 1'b1, 1'b1);
        chk("clr_overrun", 32'(overrun), 32'd0);
        chk("clr_valid", 32'(bus.out_valid), 32'd0);

        // Sparse strobes, then a back-to-back frame with no idle strobe between
        send_frame(4'hC, 1'b0, STOP_BIT, 1'b1, 3);
        chk("sparse_data", 32'(bus.out_data), 32'hC);
        chk("sparse_valid", 32'(bus.out_valid), 32'd1);
        send_frame(4'h5, 1'b0, STOP_BIT, 1'b1, 3);
        chk("b2b_data", 32'(bus.out_data), 32'h5);
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);

        // Structured random frames with random strobe spacing and consumer stalls
        repeat (80) begin
            logic [W-1:0] d;
            logic         p;
            logic         s;
            d = W'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            s = ($urandom_range(0, 7) == 0) ? 1'b1 : STOP_BIT;
            send_frame(d, p, s, 1'($urandom_range(0, 2) != 0), int'($urandom_range(1, 3)));
            if ($urandom_range(0, 3) == 0) tick(1'b1, IDLE_LEVEL, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Free-running random line traffic
        repeat (4000) begin
            tick(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_serial_deframer
